motor_ramp_ctrl: RTL

Soft-start and reversal controller that sits directly upstream of the DC motor PWM stage and drives its 8-bit `speed` input plus a direction line for the H-bridge. It slews the commanded speed toward a target at a fixed, parameterised rate. Direction changes are only allowed after the motor has been ramped to zero and a dead time has elapsed. An emergency brake input forces zero speed at once.

---
 rtl/motor_ramp_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - soft-start / reversal speed ramp for the motor PWM stage
// Slews speed toward the effective target once per tick; reversals pass through zero and a dead time.
module motor_ramp_ctrl #(
    parameter int STEP_DIV    = 1024,
    parameter int STEP        = 4,
    parameter int DEAD_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] target,
    input  logic       target_dir,
    input  logic       brake,
    output logic [7:0] speed,
    output logic       dir,
    output logic       at_target
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    typedef enum logic [1:0] {RUN, REVERSE, DEAD, BRAKE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [7:0]    speed_q, speed_d;
    logic          dir_q, dir_d;
    logic          at_target_q, at_target_d;

    logic       tick;
    logic [7:0] eff_target;
    logic [8:0] up9, dn9;
    logic [7:0] ramp_up, ramp_dn, ramp_zero;

    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        eff_target = enable ? target : 8'd0;
        // 9-bit sums: bit 8 flags overflow above 255 or borrow below 0
        up9        = {1'b0, speed_q} + STEP9;
        dn9        = {1'b0, speed_q} - STEP9;
        ramp_up    = (up9 > {1'b0, eff_target}) ? eff_target : up9[7:0];
        ramp_dn    = (dn9[8] || (dn9[7:0] < eff_target)) ? eff_target : dn9[7:0];
        ramp_zero  = dn9[8] ? 8'd0 : dn9[7:0];
    end

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        dir_d       = dir_q;
        dead_d      = dead_q;
        at_target_d = (state_q == RUN) && (speed_q == eff_target) && (dir_q == target_dir);
        if (brake) begin
            state_d = BRAKE;
            speed_d = 8'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (target_dir != dir_q) begin
                        if (speed_q != 8'd0) begin
                            state_d = REVERSE;
                        end else begin
                            state_d = DEAD;
                            dead_d  = DEAD_LOAD;
                        end
                    end else if (tick) begin
                        if (speed_q < eff_target) begin
                            speed_d = ramp_up;
                        end else if (speed_q > eff_target) begin
                            speed_d = ramp_dn;
                        end
                    end
                end
                REVERSE: begin
                    if (target_dir == dir_q) begin
                        state_d = RUN;
                    end else if (tick) begin
                        speed_d = ramp_zero;
                        if (ramp_zero == 8'd0) begin
                            state_d = DEAD;
                            dead_d  = DEAD_LOAD;
                        end
                    end
                end
                DEAD: begin
                    speed_d = 8'd0;
                    if (dead_q == '0) begin
                        state_d = RUN;
                        dir_d   = target_dir;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                BRAKE: begin
                    // brake just released: the full dead time applies before any direction commit
                    speed_d = 8'd0;
                    state_d = DEAD;
                    dead_d  = DEAD_LOAD;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            dead_q      <= '0;
            speed_q     <= 8'd0;
            dir_q       <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dead_q      <= dead_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            at_target_q <= at_target_d;
        end
    end

    assign speed     = speed_q;
    assign dir       = dir_q;
    assign at_target = at_target_q;

endmodule
